// File: rtl/sfp_norm_pkg.sv
// Shared state encoding, default geometry and width helpers for the sfp normaliser.
// Optional cross-core sum exchange is enabled with SFP_NORM_EXT_SUM_EN.
package sfp_norm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_XCHG,
        S_DIV,
        S_OUT
    } state_t;

    localparam int DEF_COL       = 8;
    localparam int DEF_BW_PSUM   = 20;
    localparam int DEF_SUM_SHIFT = 7;
    localparam int DEF_FRAC      = 8;

    // Guard bits so that the abs-sum of up to 16 lanes never wraps
    localparam int SUM_GUARD = 4;

    function automatic int sum_w(input int bw);
        return bw + SUM_GUARD;
    endfunction

    function automatic int div_w(input int bw, input int fr);
        return bw + fr;
    endfunction

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // Largest positive lane magnitude; results saturate to +/- this value
    function automatic logic [63:0] mag_max(input int bw);
        return (64'd1 << (bw - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/sfp_norm_seq_norm_div.sv
// Unsigned restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; done pulses when the quotient is final.
module norm_div
    import sfp_norm_pkg::*;
#(
    parameter int dw = div_w(DEF_BW_PSUM, DEF_FRAC),
    parameter int vw = sum_w(DEF_BW_PSUM) - DEF_SUM_SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [dw-1:0] dividend,
    input  logic [vw-1:0] divisor,
    output logic          done,
    output logic [dw-1:0] quotient
);

    localparam int CW = $clog2(dw + 1);

    logic [dw-1:0] q_q;
    logic [vw-1:0] rem_q;
    logic [vw-1:0] dvs_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic [vw:0]   rem_sh;
    logic [vw-1:0] diff;
    logic          ge;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        rem_sh = {rem_q, q_q[dw-1]};
        ge     = rem_sh >= {1'b0, dvs_q};
        diff   = rem_sh[vw-1:0] - dvs_q;
    end

    // Quotient bits shift in where dividend bits shift out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            q_q   <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= CW'(dw);
            run_q <= 1'b1;
            done  <= 1'b0;
        end else if (run_q) begin
            q_q   <= {q_q[dw-2:0], ge};
            rem_q <= ge ? diff : rem_sh[vw-1:0];
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
                done  <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = q_q;

endmodule

// File: rtl/sfp_norm_seq.sv
// Sequential psum normaliser: abs-sum, optional partner-sum exchange, per-lane divide.
// Define SFP_NORM_EXT_SUM_EN to add the sum_* ports and the XCHG state.
module sfp_norm_seq
    import sfp_norm_pkg::*;
#(
    parameter int col       = DEF_COL,
    parameter int bw_psum   = DEF_BW_PSUM,
    parameter int sum_shift = DEF_SUM_SHIFT,
    parameter int frac      = DEF_FRAC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*bw_psum-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*bw_psum-1:0]   out_data,
`ifdef SFP_NORM_EXT_SUM_EN
    output logic [bw_psum+3:0]       sum_out,
    output logic                     sum_out_valid,
    input  logic [bw_psum+3:0]       sum_in,
    input  logic                     sum_in_valid,
    output logic                     sum_in_ready,
`endif
    output logic                     busy
);

    localparam int SW = sum_w(bw_psum);
    localparam int DW = div_w(bw_psum, frac);
    localparam int VW = SW - sum_shift;
    localparam int IW = idx_w(col);
    localparam logic [IW-1:0] LAST    = IW'(col - 1);
    localparam logic [DW-1:0] MAG_MAX = DW'(mag_max(bw_psum));

    state_t             state_q;
    logic [bw_psum-1:0] lane_q [col];
    logic [SW-1:0]      sum_q;
    logic [IW-1:0]      idx_q;
    logic               first_q;
    logic [VW-1:0]      dvs;

    logic [bw_psum-1:0] acc_lane;
    logic [bw_psum-1:0] acc_mag;
    logic [IW-1:0]      ld_idx;
    logic [bw_psum-1:0] ld_lane;
    logic [bw_psum-1:0] ld_mag;
    logic [DW-1:0]      dividend;
    logic               div_start;
    logic               div_done;
    logic [DW-1:0]      div_q;
    logic               sat;
    logic [bw_psum-1:0] res_mag;
    logic [bw_psum-1:0] res;

`ifdef SFP_NORM_EXT_SUM_EN
    logic [VW-1:0] dvs_q;
    logic [SW:0]   xsum;
    assign xsum    = {1'b0, sum_q} + {1'b0, sum_in};
    assign sum_out = sum_q;
    assign dvs     = dvs_q;
`else
    assign dvs = sum_q[SW-1:sum_shift];
`endif

    // Lane magnitudes, divider feed and signed, clamped lane result
    always_comb begin
        acc_lane  = lane_q[idx_q];
        acc_mag   = acc_lane[bw_psum-1] ? ('0 - acc_lane) : acc_lane;
        ld_idx    = first_q ? '0 : idx_q + IW'(1);
        ld_lane   = lane_q[ld_idx];
        ld_mag    = ld_lane[bw_psum-1] ? ('0 - ld_lane) : ld_lane;
        dividend  = {ld_mag, {frac{1'b0}}};
        div_start = (state_q == S_DIV)
                  && (first_q || (div_done && idx_q != LAST));
        sat       = (dvs == '0) || (div_q > MAG_MAX);
        res_mag   = '0;
        if (acc_lane != '0) begin
            res_mag = sat ? MAG_MAX[bw_psum-1:0] : div_q[bw_psum-1:0];
        end
        res = acc_lane[bw_psum-1] ? ('0 - res_mag) : res_mag;
    end

    norm_div #(
        .dw (DW),
        .vw (VW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (dvs),
        .done     (div_done),
        .quotient (div_q)
    );

    // Control FSM with registered handshake outputs and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            first_q   <= 1'b0;
            for (int i = 0; i < col; i++) begin
                lane_q[i] <= '0;
            end
`ifdef SFP_NORM_EXT_SUM_EN
            dvs_q         <= '0;
            sum_out_valid <= 1'b0;
            sum_in_ready  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < col; i++) begin
                            lane_q[i] <= in_data[i*bw_psum +: bw_psum];
                        end
                        sum_q    <= '0;
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= S_ACC;
                    end
                end
                S_ACC: begin
                    sum_q <= sum_q + SW'(acc_mag);
                    if (idx_q == LAST) begin
                        idx_q <= '0;
`ifdef SFP_NORM_EXT_SUM_EN
                        sum_out_valid <= 1'b1;
                        sum_in_ready  <= 1'b1;
                        state_q       <= S_XCHG;
`else
                        first_q <= 1'b1;
                        state_q <= S_DIV;
`endif
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_XCHG: begin
`ifdef SFP_NORM_EXT_SUM_EN
                    if (sum_in_valid) begin
                        dvs_q <= xsum[SW] ? '1 : xsum[SW-1:sum_shift];
                        sum_out_valid <= 1'b0;
                        sum_in_ready  <= 1'b0;
                        first_q       <= 1'b1;
                        state_q       <= S_DIV;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                S_DIV: begin
                    first_q <= 1'b0;
                    if (div_done) begin
                        out_data[idx_q*bw_psum +: bw_psum] <= res;
                        if (idx_q == LAST) begin
                            out_valid <= 1'b1;
                            state_q   <= S_OUT;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sfp_norm_seq.md
# sfp_norm_seq

Sequential, parametrised special-function normaliser between the psum memory and the output path of the attention core. For each accepted psum vector of `col` signed lanes, it forms the sum of absolute values and optionally combines it with a partner core's sum. It then divides every lane by the scaled total with a shared iterative divider and presents the normalised vector on a valid/ready output. It generalises the fixed single-core sfp datapath with a runtime-independent lane count, a configurable scale and fraction, back-pressure, and an optional cross-core sum exchange.

## Interface
- `col`, 8: lanes per vector; legal range 2..16.
- `bw_psum`, 20: signed lane width, for both input and output.
- `sum_shift`, 7: right shift applied to the total to form the divisor.
- `frac`, 8: left shift applied to each lane before division.

- `clk` input 1: single clock; all state is rising-edge.
- `reset` input 1: asynchronous, active-low; state is cleared while 0.
- `in_valid` input 1: `in_data` holds a vector.
- `in_ready` output 1: block is in IDLE and accepts a vector.
- `in_data` input col*bw_psum: lane i is at `[(i+1)*bw_psum-1 : i*bw_psum]`.
- `out_valid` output 1: `out_data` holds the normalised vector.
- `out_ready` input 1: consumer accepts the vector.
- `out_data` output col*bw_psum: normalised lanes, same packing as `in_data`.
- `busy` output 1: block is in any state other than IDLE.
- `sum_out`, `sum_out_valid` output bw_psum+4, 1: local abs-sum. Present only with the macro.
- `sum_in`, `sum_in_valid`, `sum_in_ready` input bw_psum+4, input 1, output 1: partner abs-sum. Present only with the macro.

## Operation
- FSM states are IDLE, ACC, XCHG, DIV and OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&in_ready`, latch all lanes, clear the sum and go to ACC.
- ACC:
  - One lane per cycle, in order lane 0 to col-1: sum += |lane|.
  - |−2^(bw_psum−1)| is taken as 2^(bw_psum−1), unsigned.
  - After col cycles, go to XCHG if the macro is defined, otherwise to DIV.
- XCHG:
  - `sum_out_valid`=1 and `sum_in_ready`=1.
  - When `sum_in_valid` is high, set total = local + `sum_in` and go to DIV.
  - If the addition overflows, total saturates to all-ones.
  - `sum_out_valid` drops in the cycle after the transfer.
- DIV:
  - d = total[bw_psum+3:sum_shift].
  - For each lane in order, `norm_div` computes floor((|x|<<frac)/d).
  - The sign of x is reapplied; the result truncates toward zero.
  - A magnitude above 2^(bw_psum−1)−1 clamps to ±(2^(bw_psum−1)−1).
  - If d==0: a nonzero lane gives ±max and a zero lane gives 0.
- OUT:
  - `out_valid`=1 and `out_data` is held stable.
  - On `out_valid&out_ready`, go to IDLE.
  - `in_ready` rises in the next cycle, so there is no same-cycle re-accept.
- Reset mid-operation: the FSM returns to IDLE asynchronously and the partial sum and quotients are discarded.

## Timing
- Reset values:
  - `in_ready`=1 once reset=1, and 0 while reset=0.
  - `out_valid`=0, `out_data`=0, `busy`=0.
  - `sum_out`=0, `sum_out_valid`=0, `sum_in_ready`=0.
- Let W = bw_psum+frac. `norm_div` takes W cycles per lane plus 1 start cycle.
- Latency from the accept edge to `out_valid` is 1 + col + col*(W+1). With defaults that is 241 cycles; add the XCHG wait when the macro is defined.
- Throughput: one vector per latency plus 1 cycle.
- `in_data` is sampled only on the accept edge and may change afterwards.

## Configuration
- `SFP_NORM_EXT_SUM_EN` defined:
  - The `sum_*` ports exist and the XCHG state is used.
  - The divisor uses local+partner sum, giving dual-core normalisation.
- Undefined:
  - The ports and state are removed and total = local sum.
  - Latency is exactly the formula above.

## Structure
- Package `sfp_norm_pkg` holds:
  - the state enum;
  - localparams for sum width (bw_psum+4), dividend width W, and the lane-index width;
  - the saturation constants.
- Sub-module `norm_div`:
  - unsigned restoring divider, one quotient bit per cycle;
  - start/done handshake, with dividend W and divisor bw_psum+4−sum_shift bits.
- The top level holds the FSM, lane registers, abs-accumulator, sign/clamp logic and output register.

## Test plan
- Reset: hold reset=0 for 5 cycles and release → `in_ready`=1, `out_valid`=0, `busy`=0.
- All lanes 100 (defaults, macro off) → sum 800, d=6, every lane = 4266 (0x010AA); `out_valid` rises 241 cycles after accept.
- Lane0=−256, others 0 → d=2, lane0=−32768, others 0.
- All lanes 1 → d=0, every lane = 0x7FFFF (saturated).
- Hold `out_ready`=0 for 50 cycles → `out_data` stays stable and `in_ready`=0. A second vector is accepted only in the cycle after the out handshake. Assert reset mid-DIV → IDLE, `out_valid`=0.
- Macro on, all lanes 100, `sum_in`=2048 delayed 10 cycles → `sum_out`=800, d=22, every lane = 1163.
